// File: rtl/fft_seq_pkg.sv
// Shared constants and state encoding for the FFT frame sequencer.
package fft_seq_pkg;
  localparam int FFT_FRAME_LEN = 256;
  localparam int FFT_CORE_N    = 8;
  localparam int FFT_DATA_W    = 12;
  localparam int FFT_ADDR_W    = $clog2(FFT_FRAME_LEN);
  localparam int FFT_BLOCKS    = FFT_FRAME_LEN / FFT_CORE_N;
  localparam int FFT_TIMEOUT   = 64;

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, STORE, DONE} fft_seq_state_t;
endpackage

// File: rtl/fft_frame_sequencer.sv
// Walks one frame through the shared 8-point FFT core block by block,
// writing core outputs to the result buffer in block-natural bin order.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | 9 cycles: issue 8 sample reads, capture returning data
// ISSUE | pulse core_in_valid with the loaded block
// WAIT  | wait for core_out_valid, bounded by TIMEOUT
// STORE | 8 cycles: write one bin per cycle
// DONE  | one-cycle frame completion pulse
module fft_frame_sequencer
  import fft_seq_pkg::*;
#(
  parameter int FRAME_LEN = FFT_FRAME_LEN,
  parameter int CORE_N    = FFT_CORE_N,
  parameter int DATA_W    = FFT_DATA_W,
  parameter int TIMEOUT   = FFT_TIMEOUT,
  localparam int ADDR_W   = $clog2(FRAME_LEN),
  localparam int BUS_W    = CORE_N * DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              smp_rd_en,
  output logic [ADDR_W-1:0] smp_rd_addr,
  input  logic [DATA_W-1:0] smp_rd_data,
  output logic [BUS_W-1:0]  core_x,
  output logic              core_in_valid,
  input  logic [BUS_W-1:0]  core_y_r,
  input  logic [BUS_W-1:0]  core_y_i,
  input  logic              core_out_valid,
  output logic              res_we,
  output logic [ADDR_W-1:0] res_addr,
  output logic [DATA_W-1:0] res_real,
  output logic [DATA_W-1:0] res_imag
);
  localparam int BLOCKS = FRAME_LEN / CORE_N;
  localparam int BLK_W  = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;
  localparam int SLOT_W = $clog2(CORE_N + 1);
  localparam int TMO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  fft_seq_state_t    state_q, state_d;
  logic [BLK_W-1:0]  block_q, block_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [BUS_W-1:0]  x_q, x_d, yr_q, yr_d, yi_q, yi_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] smp_addr_q, smp_addr_d, res_addr_q, res_addr_d;
  logic [DATA_W-1:0] res_real_q, res_real_d, res_imag_q, res_imag_d;
  logic [ADDR_W-1:0] addr_cur;

  assign addr_cur = ADDR_W'(block_q) * ADDR_W'(CORE_N) + ADDR_W'(slot_q);

  // Both banks are shift registers: the first sample captured lands in slot 0,
  // and STORE always emits the LSB slot, so no slot indexing is needed.
  always_comb begin
    state_d       = state_q;
    block_d       = block_q;
    slot_d        = slot_q;
    tmo_d         = tmo_q;
    x_d           = x_q;
    yr_d          = yr_q;
    yi_d          = yi_q;
    err_d         = err_q;
    smp_addr_d    = smp_addr_q;
    res_addr_d    = res_addr_q;
    res_real_d    = res_real_q;
    res_imag_d    = res_imag_q;
    smp_rd_en     = 1'b0;
    core_in_valid = 1'b0;
    res_we        = 1'b0;
    done          = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          err_d   = 1'b0;
          block_d = '0;
          slot_d  = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (slot_q < SLOT_W'(CORE_N)) begin
          smp_rd_en  = 1'b1;
          smp_addr_d = addr_cur;
        end
        if (slot_q != '0) x_d = {smp_rd_data, x_q[BUS_W-1:DATA_W]};
        if (slot_q == SLOT_W'(CORE_N)) begin
          slot_d  = '0;
          state_d = ISSUE;
        end else begin
          slot_d = slot_q + 1'b1;
        end
      end
      ISSUE: begin
        core_in_valid = 1'b1;
        tmo_d         = TMO_W'(TIMEOUT - 1);
        state_d       = WAIT;
      end
      WAIT: begin
        if (core_out_valid) begin
          yr_d    = core_y_r;
          yi_d    = core_y_i;
          state_d = STORE;
        end else if (tmo_q == '0) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          tmo_d = tmo_q - 1'b1;
        end
      end
      STORE: begin
        res_we     = 1'b1;
        res_addr_d = addr_cur;
        res_real_d = yr_q[DATA_W-1:0];
        res_imag_d = yi_q[DATA_W-1:0];
        yr_d       = yr_q >> DATA_W;
        yi_d       = yi_q >> DATA_W;
        if (slot_q == SLOT_W'(CORE_N - 1)) begin
          slot_d = '0;
          if (block_q == BLK_W'(BLOCKS - 1)) begin
            state_d = DONE;
          end else begin
            block_d = block_q + 1'b1;
            state_d = LOAD;
          end
        end else begin
          slot_d = slot_q + 1'b1;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      block_q    <= '0;
      slot_q     <= '0;
      tmo_q      <= '0;
      x_q        <= '0;
      yr_q       <= '0;
      yi_q       <= '0;
      err_q      <= 1'b0;
      smp_addr_q <= '0;
      res_addr_q <= '0;
      res_real_q <= '0;
      res_imag_q <= '0;
    end else begin
      state_q    <= state_d;
      block_q    <= block_d;
      slot_q     <= slot_d;
      tmo_q      <= tmo_d;
      x_q        <= x_d;
      yr_q       <= yr_d;
      yi_q       <= yi_d;
      err_q      <= err_d;
      smp_addr_q <= smp_addr_d;
      res_addr_q <= res_addr_d;
      res_real_q <= res_real_d;
      res_imag_q <= res_imag_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign err         = err_q;
  assign core_x      = x_q;
  assign smp_rd_addr = smp_addr_d;
  assign res_addr    = res_addr_d;
  assign res_real    = res_real_d;
  assign res_imag    = res_imag_d;
endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Scoreboard bench for fft_frame_sequencer with a behavioural sample buffer and FFT core.
module tb_fft_frame_sequencer;
  import fft_seq_pkg::*;
  localparam int DW = FFT_DATA_W;
  localparam int NC = FFT_CORE_N;
  localparam int BW = NC * DW;
  localparam int NF = FFT_FRAME_LEN;
  localparam int NB = FFT_BLOCKS;
  localparam int AW = FFT_ADDR_W;

  logic clk, rst, start, busy, done, err, smp_rd_en, core_in_valid, core_out_valid, res_we;
  logic [AW-1:0] smp_rd_addr, res_addr;
  logic [DW-1:0] smp_rd_data, res_real, res_imag;
  logic [BW-1:0] core_x, core_y_r, core_y_i;

  fft_frame_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
    .smp_rd_en(smp_rd_en), .smp_rd_addr(smp_rd_addr), .smp_rd_data(smp_rd_data),
    .core_x(core_x), .core_in_valid(core_in_valid), .core_y_r(core_y_r),
    .core_y_i(core_y_i), .core_out_valid(core_out_valid), .res_we(res_we),
    .res_addr(res_addr), .res_real(res_real), .res_imag(res_imag)
  );

  typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] re; logic [DW-1:0] im;} wr_t;
  typedef struct {int t; logic e;} dn_t;

  wr_t wq[$];
  dn_t dq[$];
  logic [DW-1:0] mem [NF];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int nwr = 0;
  int ndone = 0;
  int lat = 3;
  bit core_en = 1;
  bit spur_mode = 0;
  int core_cnt = 0;
  logic [BW-1:0] held_x;
  logic prev_en = 0;
  logic [AW-1:0] prev_addr = '0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Sample buffer (1-cycle read latency) and core model: y_r = x, y_i = ~x after lat cycles.
  initial begin
    smp_rd_data = '0; core_out_valid = 0; core_y_r = '0; core_y_i = '0;
    forever begin
      @(posedge clk); #1;
      smp_rd_data = prev_en ? mem[prev_addr] : DW'($urandom);
      prev_en = smp_rd_en;
      prev_addr = smp_rd_addr;
      core_out_valid = 0;
      core_y_r = {$urandom, $urandom, $urandom};
      core_y_i = {$urandom, $urandom, $urandom};
      if (core_cnt > 0) begin
        core_cnt--;
        if (core_cnt == 0) begin
          core_out_valid = 1;
          core_y_r = held_x;
          core_y_i = ~held_x;
        end
      end else if (spur_mode && (!busy || (smp_rd_en && smp_rd_addr == AW'(17)))) begin
        core_out_valid = 1;
      end
      if (core_in_valid && core_en) begin
        held_x = core_x;
        core_cnt = lat;
      end
    end
  end

  // Monitor: pops expected writes / done events as the DUT presents them.
  initial forever begin
    @(negedge clk);
    if (res_we) begin
      nwr++;
      checks++;
      if (wq.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected actual addr=%0d required none", res_addr);
      end else begin
        wr_t e;
        e = wq.pop_front();
        if ({res_addr, res_real, res_imag} !== e) begin
          errors++;
          $display("FAIL write actual a=%0d re=%h im=%h required a=%0d re=%h im=%h",
                   res_addr, res_real, res_imag, e.a, e.re, e.im);
        end
      end
    end
    if (done) begin
      ndone++;
      checks++;
      if (dq.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected actual cycle=%0d required none", cyc);
      end else begin
        dn_t d;
        d = dq.pop_front();
        if (cyc != d.t || err !== d.e) begin
          errors++;
          $display("FAIL done actual cycle=%0d err=%0b required cycle=%0d err=%0b",
                   cyc, err, d.t, d.e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctrl"}, {busy, done, err, smp_rd_en, core_in_valid, res_we}, 0);
    chk({tag, "_addr"}, {smp_rd_addr, res_addr}, 0);
    chk({tag, "_res"}, {res_real, res_imag}, 0);
    chk({tag, "_core_x"}, 64'(|core_x), 0);
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < NF; i++) mem[i] = DW'(i);
  endtask

  task automatic fill_random();
    for (int i = 0; i < NF; i++) mem[i] = DW'($urandom);
  endtask

  task automatic push_frame(input int t0, input int L);
    for (int a = 0; a < NF; a++) wq.push_back('{a: AW'(a), re: mem[a], im: ~mem[a]});
    dq.push_back('{t: t0 + NB * (18 + L) + 1, e: 1'b0});
  endtask

  task automatic start_frame(input int L);
    push_frame(cyc, L);
    start = 1;
    step();
    start = 0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (ndone < target && n < budget) begin
      step();
      n++;
    end
    chk("done_seen", ndone, target);
    if (ndone >= target) chk("busy_after_done", busy, 0);
  endtask

  initial begin
    int t0, base, n;
    rst = 1; start = 0;
    repeat (3) step();
    check_zero("reset_held");
    rst = 0;
    repeat (2) step();
    check_zero("reset_released");

    // Ramp frame, L=3, with a stray start mid-frame.
    fill_ramp(); lat = 3;
    base = nwr; t0 = cyc;
    start_frame(3);
    while (cyc < t0 + 100) step();
    start = 1; step(); start = 0;
    wait_done(1, 1000);
    chk("err_clean", err, 0);
    repeat (20) step();
    chk("single_done", ndone, 1);
    chk("write_count", nwr - base, NF);
    chk("queue_drained", wq.size(), 0);

    // Hung core: timeout at t0+75 with err held until next start.
    core_en = 0;
    dq.push_back('{t: cyc + 75, e: 1'b1});
    base = nwr;
    start = 1; step(); start = 0;
    wait_done(2, 200);
    chk("timeout_no_writes", nwr - base, 0);
    repeat (10) step();
    chk("err_held", err, 1);
    core_en = 1; fill_random();
    push_frame(cyc, 3);
    start = 1;
    chk("err_before_start", err, 1);
    step();
    chk("err_cleared", err, 0);
    start = 0;
    wait_done(3, 1000);

    // Reset during block 5 STORE.
    fill_random();
    base = nwr;
    start_frame(3);
    n = 0;
    while (nwr < base + 5 * NC + 4 && n < 1000) begin step(); n++; end
    chk("reached_block5", nwr - base, 5 * NC + 4);
    rst = 1;
    #1;
    check_zero("reset_mid");
    wq.delete(); dq.delete();
    repeat (2) step();
    rst = 0;
    repeat (3) step();
    chk("no_done_after_abort", ndone, 3);
    start_frame(3);
    wait_done(4, 1000);

    // Spurious core_out_valid in IDLE and during block 2 LOAD.
    fill_ramp(); spur_mode = 1;
    repeat (10) step();
    chk("spur_idle_busy", busy, 0);
    start_frame(3);
    wait_done(5, 1000);
    spur_mode = 0;

    // start held high, L=1: back-to-back frames, one IDLE cycle apart.
    fill_random(); lat = 1;
    t0 = cyc;
    for (int f = 0; f < 3; f++) push_frame(t0 + f * (NB * 19 + 2), 1);
    start = 1;
    wait_done(6, 1000);
    wait_done(7, 1000);
    wait_done(8, 1000);
    start = 0;
    repeat (5) step();
    chk("held_start_stopped", busy, 0);

    // Randomized core latency.
    for (int r = 0; r < 2; r++) begin
      fill_random();
      lat = int'($urandom_range(1, 6));
      start_frame(lat);
      wait_done(9 + r, 1500);
    end
    repeat (5) step();
    chk("final_queue_empty", wq.size() + dq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fft_frame_sequencer.md
Name: fft_frame_sequencer

Overview:
- Sequences one 256-sample frame through the shared 8-point FFT core (fft_top_1), 8 samples at a time, inside top_fft.
- Reads samples from the frame buffer and presents 8-sample blocks to the core with a valid pulse.
- Collects the 8 complex outputs, writes them to the result buffer and signals frame completion.
- Bins are written in block-natural order (block*8+k); reordering or twiddle recombination belongs downstream.

Parameters:
- FRAME_LEN, 256, samples per frame; must be a multiple of CORE_N.
- CORE_N, 8, points per core transform.
- DATA_W, 12, sample and result width.
- TIMEOUT, 64, maximum WAIT cycles before the core is declared hung.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  frame request; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at frame end.
- err  out  1  core timeout flag; held until the next accepted start.
- smp_rd_en  out  1  sample buffer read strobe.
- smp_rd_addr  out  8  sample address (clog2 FRAME_LEN).
- smp_rd_data  in  DATA_W  read data, valid 1 cycle after smp_rd_en.
- core_x  out  CORE_N*DATA_W  packed block to core; slot 0 in the LSBs.
- core_in_valid  out  1  one-cycle pulse to start the core.
- core_y_r  in  CORE_N*DATA_W  core real outputs, packed.
- core_y_i  in  CORE_N*DATA_W  core imaginary outputs, packed.
- core_out_valid  in  1  core result strobe.
- res_we  out  1  result write enable.
- res_addr  out  8  bin index.
- res_real  out  DATA_W  real result.
- res_imag  out  DATA_W  imaginary result.

Behaviour:
- Reset: every output is 0, state is IDLE, and the block and slot counters are 0.
- Reset mid-frame aborts immediately: no done, no further writes, err cleared.
- States and transitions:
  - IDLE: on start=1 at cycle t0, clear err and block counter, go to LOAD.
  - LOAD: 9 cycles, k=0..8. For k<8, smp_rd_en=1 and smp_rd_addr=block*CORE_N+k. For k=1..8, capture smp_rd_data into slot k-1. Then go to ISSUE.
  - ISSUE: 1 cycle, core_in_valid=1. core_x is registered and stays stable until the next LOAD overwrites it.
  - WAIT: on core_out_valid=1, latch all core_y_r/core_y_i and go to STORE. If TIMEOUT WAIT cycles pass without core_out_valid, set err=1 and go to DONE.
  - STORE: 8 cycles. res_we=1, res_addr=block*CORE_N+k, res_real/res_imag = latched slot k. On the last cycle: if block is the last block, go to DONE; otherwise increment block and go to LOAD.
  - DONE: 1 cycle, done=1. Then go to IDLE.
- Timing with core latency L (core_out_valid L cycles after core_in_valid):
  - Block 0: LOAD t0+1..t0+9, ISSUE t0+10, valid at t0+10+L, STORE t0+11+L..t0+18+L.
  - Each block takes 18+L cycles; done is at t0+32*(18+L)+1.
- Handshake rules:
  - start is ignored outside IDLE, including the DONE cycle. Holding start high continuously gives back-to-back frames with one IDLE cycle between them.
  - core_out_valid outside WAIT is ignored.
  - When not written, res_* and smp_rd_addr hold their last value; strobes are 0.
- Width rules:
  - Core outputs are passed through unmodified; there is no scaling or saturation.
  - Address arithmetic is unsigned and never wraps within a frame (max 255).

Decomposition:
- Shared package fft_seq_pkg holds:
  - state enum fft_seq_state_t {IDLE, LOAD, ISSUE, WAIT, STORE, DONE};
  - constants FFT_FRAME_LEN, FFT_CORE_N, FFT_DATA_W, FFT_ADDR_W, FFT_BLOCKS.
- No sub-module: a single FSM with block counter, slot counter, timeout counter and two register banks (input block, output block).

Test Plan:
- Bench core model: y_r=x and y_i=~x, returned after L=3. Frame samples are a ramp 0..255; start pulses at t0. Required: res_addr runs 0..255 in order with res_real=addr and res_imag=~addr; done at exactly t0+673; err=0; busy falls with done.
- start pulsed again at t0+100 during that frame -> ignored; exactly 256 writes and a single done.
- Core never asserts valid, TIMEOUT=64 -> no res_we; done=1 and err=1 at t0+75; err stays 1 until the next start; a clean rerun then clears err.
- rst asserted during block 5 STORE -> all outputs 0 in the same cycle. A new start gives a write sequence from addr 0 and a full frame.
- Spurious core_out_valid during IDLE and during LOAD of block 2 -> no state change and no writes; timing matches the first scenario.
- start held high with L=1 -> frames repeat; each done is 32*19+1=609 cycles after its start with one IDLE cycle between frames, and every frame produces an identical write stream.
